// File: rtl/p405s_dcd_br_hold_ctl.sv
// Decode-stage branch hazard sequencer: scoreboards CR0 producers and LR/CTR
// mtspr writers, holds a conditional branch in decode until its operands settle.
module p405s_dcd_br_hold_ctl #(
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned SETTLE_DLY   = 1
) (
    input  logic             CB,
    input  logic             resetCore_N,
    input  logic             dcdValid,
    input  logic             plaCr0En,
    input  logic             plaB,
    input  logic             plaBc,
    input  logic             plaMtspr,
    input  logic             dcdSprLrCtr,
    input  logic             dcdBrNeedsCr,
    input  logic             dcdBrNeedsSpr,
    input  logic             exeAdvance,
    input  logic             wbCr0Done,
    input  logic             wbSprDone,
    input  logic             flush,
    output logic             dcdHold,
    output logic             brIssue,
    output logic [1:0]       brKind,
    output logic [CNT_W-1:0] crPending,
    output logic [CNT_W-1:0] sprPending,
    output logic [7:0]       holdStat
);

    localparam int unsigned SET_W  = 2;
    localparam int unsigned STAT_W = 8;
    localparam logic [CNT_W-1:0]  PEND_FULL   = CNT_W'(MAX_INFLIGHT);
    localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_DLY);
    localparam logic [STAT_W-1:0] STAT_MAX    = '1;
    localparam logic              SETTLE_EN   = (SETTLE_DLY != 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DEP = 2'd1,
        SETTLE   = 2'd2
    } state_t;

    state_t            state;
    logic [SET_W-1:0]  settleCnt;

    logic crBusy, sprBusy, dep, structHold, fsmHold, leave;
    logic crInc, crDec, sprInc, sprDec, holdCount;

    // A simultaneous issue and completion cancel; a lone completion at zero is dropped.
    function automatic logic [CNT_W-1:0] nextPend(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec)
            nxt = cur + CNT_W'(1);
        else if (dec && !inc && (cur != '0))
            nxt = cur - CNT_W'(1);
        return nxt;
    endfunction

    always_comb begin
        crBusy     = (crPending != '0);
        sprBusy    = (sprPending != '0);
        dep        = dcdValid & plaBc & ((dcdBrNeedsCr & crBusy) | (dcdBrNeedsSpr & sprBusy));
        structHold = dcdValid & ((plaCr0En & (crPending == PEND_FULL)) |
                                 (plaMtspr & dcdSprLrCtr & (sprPending == PEND_FULL)));
        fsmHold = 1'b0;
        case (state)
            IDLE:     fsmHold = dep;
            // With no settle delay the hold drops in the cycle the dependency clears.
            WAIT_DEP: fsmHold = SETTLE_EN | dep;
            SETTLE:   fsmHold = 1'b1;
            default:  fsmHold = 1'b0;
        endcase
        dcdHold = resetCore_N & (fsmHold | structHold);
        leave   = dcdValid & exeAdvance & ~dcdHold;
        brIssue = leave & (plaB | plaBc);
        brKind  = 2'b00;
        if (brIssue) begin
            if (plaB)
                brKind = 2'b01;
            else if (dcdBrNeedsSpr)
                brKind = 2'b11;
            else
                brKind = 2'b10;
        end
        crInc     = leave & plaCr0En;
        crDec     = wbCr0Done;
        sprInc    = leave & plaMtspr & dcdSprLrCtr;
        sprDec    = wbSprDone;
        holdCount = (state != IDLE) | dep;
    end

    always_ff @(posedge CB) begin
        if (!resetCore_N) begin
            state      <= IDLE;
            settleCnt  <= '0;
            crPending  <= '0;
            sprPending <= '0;
            holdStat   <= '0;
        end else if (flush) begin
            state      <= IDLE;
            settleCnt  <= '0;
            crPending  <= '0;
            sprPending <= '0;
        end else begin
            if (holdCount && (holdStat != STAT_MAX))
                holdStat <= holdStat + STAT_W'(1);
            crPending  <= nextPend(crPending, crInc, crDec);
            sprPending <= nextPend(sprPending, sprInc, sprDec);
            case (state)
                IDLE: begin
                    if (dep)
                        state <= WAIT_DEP;
                end
                WAIT_DEP: begin
                    if (!dcdValid) begin
                        state <= IDLE;
                    end else if (!dep) begin
                        if (SETTLE_EN) begin
                            state     <= SETTLE;
                            settleCnt <= SETTLE_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                SETTLE: begin
                    if (settleCnt <= SET_W'(1)) begin
                        state     <= IDLE;
                        settleCnt <= '0;
                    end else begin
                        settleCnt <= settleCnt - SET_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    settleCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p405s_dcd_br_hold_ctl.sv
// Bench for p405s_dcd_br_hold_ctl: directed vector table, hand-built corner
// sequences, then randomized traffic against a behavioural scoreboard model.
module tb_p405s_dcd_br_hold_ctl;

    localparam int unsigned MAXI = 3;
    localparam int unsigned SD   = 1;

    typedef struct packed {
        logic rst_n, valid, cr0En, b, bc, mtspr, lrCtr, needsCr, needsSpr, adv, wbCr, wbSpr, flush;
    } in_t;

    typedef struct {
        in_t        i;
        logic       hold;
        logic       issue;
        logic [1:0] kind;
        logic [7:0] cr;
        logic [7:0] spr;
        logic [7:0] stat;
    } vec_t;

    logic       CB = 1'b0;
    logic       resetCore_N, dcdValid, plaCr0En, plaB, plaBc, plaMtspr, dcdSprLrCtr;
    logic       dcdBrNeedsCr, dcdBrNeedsSpr, exeAdvance, wbCr0Done, wbSprDone, flush;
    logic       dcdHold, brIssue;
    logic [1:0] brKind, crPending, sprPending;
    logic [7:0] holdStat;

    always #5 CB = ~CB;

    p405s_dcd_br_hold_ctl #(.MAX_INFLIGHT(MAXI), .CNT_W(2), .SETTLE_DLY(SD)) dut (
        .CB(CB), .resetCore_N(resetCore_N), .dcdValid(dcdValid), .plaCr0En(plaCr0En),
        .plaB(plaB), .plaBc(plaBc), .plaMtspr(plaMtspr), .dcdSprLrCtr(dcdSprLrCtr),
        .dcdBrNeedsCr(dcdBrNeedsCr), .dcdBrNeedsSpr(dcdBrNeedsSpr), .exeAdvance(exeAdvance),
        .wbCr0Done(wbCr0Done), .wbSprDone(wbSprDone), .flush(flush),
        .dcdHold(dcdHold), .brIssue(brIssue), .brKind(brKind),
        .crPending(crPending), .sprPending(sprPending), .holdStat(holdStat)
    );

    int nVec = 0;
    int nErr = 0;

    // Reference model: outstanding counts as integers, branch hold as a
    // "waiting" flag plus a count of settle cycles still owed.
    in_t        curIn;
    int         mCr, mSpr, mSettle, mStat;
    bit         mWait, mKnown, mDep, mLeave;
    bit         eHold, eIssue;
    logic [1:0] eKind;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chkAll(input string tag, input bit h, input bit iss, input logic [1:0] k,
                          input logic [7:0] cr, input logic [7:0] spr, input logic [7:0] st);
        chk({tag, ".dcdHold"},    8'(dcdHold),    8'(h));
        chk({tag, ".brIssue"},    8'(brIssue),    8'(iss));
        chk({tag, ".brKind"},     8'(brKind),     8'(k));
        chk({tag, ".crPending"},  8'(crPending),  cr);
        chk({tag, ".sprPending"}, 8'(sprPending), spr);
        chk({tag, ".holdStat"},   holdStat,       st);
    endtask

    task automatic modelComb();
        bit st, fsm;
        mDep = curIn.valid && curIn.bc &&
               ((curIn.needsCr && mCr > 0) || (curIn.needsSpr && mSpr > 0));
        st = curIn.valid && ((curIn.cr0En && mCr == MAXI) ||
                             (curIn.mtspr && curIn.lrCtr && mSpr == MAXI));
        if (mSettle > 0)  fsm = 1'b1;
        else if (mWait)   fsm = (SD != 0) || mDep;
        else              fsm = mDep;
        eHold  = curIn.rst_n && (fsm || st);
        mLeave = curIn.valid && curIn.adv && !eHold;
        eIssue = mLeave && (curIn.b || curIn.bc);
        if (!eIssue)           eKind = 2'b00;
        else if (curIn.b)      eKind = 2'b01;
        else if (curIn.needsSpr) eKind = 2'b11;
        else                   eKind = 2'b10;
    endtask

    task automatic modelUpdate();
        bit crI, sprI;
        if (!curIn.rst_n) begin
            mCr = 0; mSpr = 0; mSettle = 0; mStat = 0; mWait = 0; mKnown = 1;
        end else if (curIn.flush) begin
            mCr = 0; mSpr = 0; mSettle = 0; mWait = 0;
        end else begin
            if ((mWait || mSettle > 0 || mDep) && mStat < 255) mStat++;
            crI  = mLeave && curIn.cr0En;
            sprI = mLeave && curIn.mtspr && curIn.lrCtr;
            if (crI && !curIn.wbCr) mCr++;
            else if (curIn.wbCr && !crI && mCr > 0) mCr--;
            if (sprI && !curIn.wbSpr) mSpr++;
            else if (curIn.wbSpr && !sprI && mSpr > 0) mSpr--;
            if (mSettle > 0) begin
                mSettle--;
            end else if (mWait) begin
                mWait = 0;
                if (curIn.valid && mDep) mWait = 1;
                else if (curIn.valid && SD > 0) mSettle = SD;
            end else if (mDep) begin
                mWait = 1;
            end
        end
    endtask

    // Called one time unit after a rising edge; returns at the falling edge.
    task automatic applyIn(input in_t v);
        curIn = v;
        {resetCore_N, dcdValid, plaCr0En, plaB, plaBc, plaMtspr, dcdSprLrCtr,
         dcdBrNeedsCr, dcdBrNeedsSpr, exeAdvance, wbCr0Done, wbSprDone, flush} = v;
        modelComb();
        #4;
    endtask

    task automatic checkModel(input string tag);
        if (mKnown)
            chkAll(tag, eHold, eIssue, eKind, 8'(mCr), 8'(mSpr), 8'(mStat));
    endtask

    task automatic advance();
        modelUpdate();
        @(posedge CB);
        #1;
    endtask

    task automatic step(input string tag, input in_t v);
        applyIn(v);
        checkModel(tag);
        advance();
    endtask

    localparam in_t NOP   = in_t'{rst_n: 1'b1, default: 1'b0};
    localparam in_t RST   = in_t'{default: 1'b0};
    localparam in_t ADD   = in_t'{rst_n: 1'b1, valid: 1'b1, cr0En: 1'b1, adv: 1'b1, default: 1'b0};
    localparam in_t MTSPR = in_t'{rst_n: 1'b1, valid: 1'b1, mtspr: 1'b1, lrCtr: 1'b1, adv: 1'b1, default: 1'b0};
    localparam in_t BCCR  = in_t'{rst_n: 1'b1, valid: 1'b1, bc: 1'b1, needsCr: 1'b1, adv: 1'b1, default: 1'b0};
    localparam in_t BCSPR = in_t'{rst_n: 1'b1, valid: 1'b1, bc: 1'b1, needsSpr: 1'b1, adv: 1'b1, default: 1'b0};
    localparam in_t BCNO  = in_t'{rst_n: 1'b1, valid: 1'b1, bc: 1'b1, adv: 1'b1, default: 1'b0};
    localparam in_t BUNC  = in_t'{rst_n: 1'b1, valid: 1'b1, b: 1'b1, adv: 1'b1, default: 1'b0};

    vec_t tbl[$];

    initial begin
        in_t v;
        vec_t e;

        // Expected outputs as seen during each cycle, before its closing edge.
        v = BCCR;  v.wbCr = 1'b1;
        tbl.push_back('{ADD,   1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd0});
        tbl.push_back('{v,     1'b1, 1'b0, 2'b00, 8'd1, 8'd0, 8'd0});
        tbl.push_back('{BCCR,  1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 8'd1});
        tbl.push_back('{BCCR,  1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 8'd2});
        tbl.push_back('{BCCR,  1'b0, 1'b1, 2'b10, 8'd0, 8'd0, 8'd3});
        tbl.push_back('{MTSPR, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd3});
        tbl.push_back('{BCSPR, 1'b1, 1'b0, 2'b00, 8'd0, 8'd1, 8'd3});
        v = BCSPR; v.wbSpr = 1'b1;
        tbl.push_back('{v,     1'b1, 1'b0, 2'b00, 8'd0, 8'd1, 8'd4});
        tbl.push_back('{BCSPR, 1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 8'd5});
        tbl.push_back('{BCSPR, 1'b1, 1'b0, 2'b00, 8'd0, 8'd0, 8'd6});
        tbl.push_back('{BCSPR, 1'b0, 1'b1, 2'b11, 8'd0, 8'd0, 8'd7});
        tbl.push_back('{MTSPR, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd7});
        tbl.push_back('{BCNO,  1'b0, 1'b1, 2'b10, 8'd0, 8'd1, 8'd7});
        v = BUNC;  v.wbSpr = 1'b1;
        tbl.push_back('{v,     1'b0, 1'b1, 2'b01, 8'd0, 8'd1, 8'd7});
        tbl.push_back('{ADD,   1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd7});
        v = ADD;   v.wbCr = 1'b1;
        tbl.push_back('{v,     1'b0, 1'b0, 2'b00, 8'd1, 8'd0, 8'd7});
        tbl.push_back('{NOP,   1'b0, 1'b0, 2'b00, 8'd1, 8'd0, 8'd7});
        v = NOP;   v.wbCr = 1'b1;
        tbl.push_back('{v,     1'b0, 1'b0, 2'b00, 8'd1, 8'd0, 8'd7});
        tbl.push_back('{v,     1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd7});
        tbl.push_back('{NOP,   1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 8'd7});

        mKnown = 0; mCr = 0; mSpr = 0; mSettle = 0; mStat = 0; mWait = 0;
        @(posedge CB); #1;
        step("reset0", RST);
        step("reset1", RST);

        foreach (tbl[k]) begin
            e = tbl[k];
            applyIn(e.i);
            chkAll($sformatf("vec%0d", k), e.hold, e.issue, e.kind, e.cr, e.spr, e.stat);
            advance();
        end

        // Scoreboard full: a fourth CR0 producer stalls until one completes.
        step("full0", ADD); step("full1", ADD); step("full2", ADD);
        applyIn(ADD); checkModel("full3");
        chk("full_hold", 8'(dcdHold), 8'd1); chk("full_cr", 8'(crPending), 8'd3); advance();
        step("full4", ADD);
        v = ADD; v.wbCr = 1'b1;
        applyIn(v); checkModel("full5"); chk("full_hold_wb", 8'(dcdHold), 8'd1); advance();
        applyIn(ADD); checkModel("full6"); chk("full_release", 8'(dcdHold), 8'd0); advance();
        v = NOP; v.wbCr = 1'b1;
        for (int k = 0; k < 3; k++) step("drain", v);

        // Reset while a bc waits on two CR0 producers.
        step("rh0", ADD); step("rh1", ADD);
        applyIn(BCCR); checkModel("rh2"); chk("rh_hold", 8'(dcdHold), 8'd1); advance();
        step("rh3", BCCR);
        applyIn(RST); chk("rh_rst_hold", 8'(dcdHold), 8'd0); checkModel("rh4"); advance();
        applyIn(BCCR); checkModel("rh5");
        chk("rh_cr", 8'(crPending), 8'd0); chk("rh_hold_after", 8'(dcdHold), 8'd0);
        chk("rh_stat", holdStat, 8'd0); advance();

        // Flush while settling; an unconditional b issues right after.
        step("fl0", ADD);
        v = BCCR; v.wbCr = 1'b1;
        step("fl1", v); step("fl2", BCCR);
        v = BCCR; v.flush = 1'b1;
        applyIn(v); checkModel("fl3"); chk("fl_hold_flush", 8'(dcdHold), 8'd1); advance();
        applyIn(BUNC); checkModel("fl4");
        chk("fl_hold", 8'(dcdHold), 8'd0); chk("fl_issue", 8'(brIssue), 8'd1);
        chk("fl_kind", 8'(brKind), 8'd1); chk("fl_cr", 8'(crPending), 8'd0); advance();

        // Decode killed while waiting: no issue, hold gone next cycle.
        step("kl0", ADD); step("kl1", BCCR); step("kl2", NOP);
        applyIn(NOP); checkModel("kl3"); chk("kl_hold", 8'(dcdHold), 8'd0); advance();
        v = NOP; v.wbCr = 1'b1;
        step("kl4", v);

        // Hold-cycle statistic saturates.
        step("sat0", ADD);
        for (int k = 0; k < 270; k++) begin
            applyIn(BCCR); if (k % 50 == 0) checkModel("sat"); advance();
        end
        applyIn(BCCR); chk("sat_stat", holdStat, 8'd255); checkModel("sat_end"); advance();
        v = NOP; v.flush = 1'b1;
        step("sat_flush", v);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = int'($urandom_range(0, 7));
            v.rst_n    = ($urandom_range(0, 99) != 0);
            v.valid    = ($urandom_range(0, 3) != 0);
            v.cr0En    = (r < 2);
            v.mtspr    = (r == 2);
            v.b        = (r == 5) || (r == 7);
            v.bc       = (r == 3) || (r == 4) || (r == 7 && $urandom_range(0, 3) == 0);
            v.lrCtr    = ($urandom_range(0, 3) != 0);
            v.needsCr  = 1'($urandom_range(0, 1));
            v.needsSpr = 1'($urandom_range(0, 1));
            v.adv      = ($urandom_range(0, 3) != 0);
            v.wbCr     = ($urandom_range(0, 2) == 0);
            v.wbSpr    = ($urandom_range(0, 2) == 0);
            v.flush    = ($urandom_range(0, 39) == 0);
            step("rnd", v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
